// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU; returns {remainder, quotient}.
// The execute stage holds start_i (and the operands) until ready_o is seen.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 Rst_n,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {ST_FREE, ST_BYZERO, ST_ON, ST_END} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2*WIDTH:0]  dividend;
  logic [WIDTH-1:0]  divisor;
  logic              neg_q;
  logic              neg_r;

  logic [WIDTH-1:0]  mag1, mag2, q, r;
  logic [WIDTH:0]    diff;

  always_comb begin
    mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    diff = {1'b0, dividend[2*WIDTH-1:WIDTH]} - {1'b0, divisor};
    q    = neg_q ? -dividend[WIDTH-1:0] : dividend[WIDTH-1:0];
    // remainder takes the dividend's sign
    r    = neg_r ? -dividend[2*WIDTH:WIDTH+1] : dividend[2*WIDTH:WIDTH+1];
  end

  always_ff @(posedge clk) begin
    if (!Rst_n) begin
      state    <= ST_FREE;
      cnt      <= '0;
      dividend <= '0;
      divisor  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        ST_FREE: begin
          result_o <= '0;
          ready_o  <= 1'b0;
          if (start_i && !annul_i) begin
            dividend <= {{WIDTH{1'b0}}, mag1, 1'b0};
            divisor  <= mag2;
            neg_q    <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_r    <= signed_div_i && opdata1_i[WIDTH-1];
            cnt      <= '0;
            state    <= (opdata2_i == '0) ? ST_BYZERO : ST_ON;
          end
        end
        ST_BYZERO: begin
          result_o <= '0;
          if (annul_i) begin
            ready_o <= 1'b0;
            state   <= ST_FREE;
          end else begin
            ready_o <= 1'b1;
            state   <= ST_END;
          end
        end
        ST_ON: begin
          if (annul_i) begin
            result_o <= '0;
            ready_o  <= 1'b0;
            state    <= ST_FREE;
          end else if (cnt != LAST) begin
            if (diff[WIDTH])
              dividend <= dividend << 1;
            else
              dividend <= {diff[WIDTH-1:0], dividend[WIDTH-1:0], 1'b1};
            cnt <= cnt + 1'b1;
          end else begin
            result_o <= {r, q};
            ready_o  <= 1'b1;
            state    <= ST_END;
          end
        end
        ST_END: begin
          if (annul_i || !start_i) begin
            result_o <= '0;
            ready_o  <= 1'b0;
            state    <= ST_FREE;
          end
        end
        default: begin
          result_o <= '0;
          ready_o  <= 1'b0;
          state    <= ST_FREE;
        end
      endcase
    end
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle signed/unsigned 32-bit divider that serves DIV/DIVU issued from the decode stage. The execute stage acts as initiator: it presents operands with `start_i`, holds them, and stalls the pipeline until `ready_o`. On completion the unit returns `{remainder, quotient}` for the HI/LO write. It sits beside the execute stage and is driven only by it.

## Interface
- `WIDTH`, default 32: operand width; also the iteration count.
- `clk` in 1: clock, rising edge.
- `Rst_n` in 1: reset, synchronous, active-low.
- `signed_div_i` in 1: 1 = DIV (two's complement), 0 = DIVU.
- `opdata1_i` in WIDTH: dividend; stable while busy.
- `opdata2_i` in WIDTH: divisor; stable while busy.
- `start_i` in 1: request; held high until `ready_o` is seen.
- `annul_i` in 1: abort the current operation, e.g. on flush.
- `result_o` out 2*WIDTH: `{remainder[WIDTH-1:0], quotient[WIDTH-1:0]}`.
- `ready_o` out 1: result valid.

## Operation
- States:
  - **FREE**: idle.
  - **BYZERO**: divisor is zero.
  - **ON**: iterating.
  - **END**: result presented.
- **Reset.** `Rst_n`=0 at an edge gives state FREE, `ready_o`=0, `result_o`=0, counter 0, working regs 0. This holds even mid-operation.
- **FREE**
  - `start_i`=1 and `annul_i`=0 with `opdata2_i`=0: go to BYZERO.
  - `start_i`=1 and `annul_i`=0 otherwise: go to ON and clear the counter.
  - Operand latch: when signed and the MSB is set, latch the two's-complement magnitude, otherwise the raw value. Latch |op1| into `dividend[WIDTH:1]` of a 2*WIDTH+1 register, with the rest 0, and latch |op2| into `divisor`.
  - Otherwise stay in FREE, with `ready_o`=0 and `result_o`=0.
- **ON**, each edge while counter < WIDTH (restoring division):
  - `diff = {1'b0, dividend[2W-1:W]} - {1'b0, divisor}`, computed WIDTH+1 bits wide.
  - If `diff[W]`=1: `dividend <= dividend << 1`.
  - Else: `dividend <= {diff[W-1:0], dividend[W-1:0], 1'b1}`.
  - The counter increments.
- **ON completion.** On the edge with counter == WIDTH:
  - Quotient `q = dividend[W-1:0]`; remainder `r = dividend[2W:W+1]`.
  - If signed and the op1/op2 MSBs differ: negate q.
  - If signed and the op1 MSB is set: negate r. The remainder sign follows the dividend.
  - Register `result_o={r,q}` and `ready_o`=1, and go to END.
- **BYZERO.** Next edge goes to END with `result_o`=0 and `ready_o`=1.
- **END.** Hold `result_o` and `ready_o` while `start_i`=1. When `start_i`=0 at an edge, go to FREE with `ready_o`=0 and `result_o`=0.
- **Annul.** `annul_i`=1 at any edge in ON, BYZERO or END:
  - Go to FREE with `ready_o`=0 and `result_o`=0.
  - Annul takes priority over completion on the same edge.
- **Overflow case.** Signed 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0; no trap.
- **Sign sampling.** Operand sign bits are latched in FREE; later operand changes have no effect.

## Timing
- Let E0 be the edge that samples the start in FREE.
- Normal divide: E0 enters ON, E1..E32 iterate, and E33 enters END. `ready_o` is high from E33, giving a latency of WIDTH+1 = 33 cycles.
- Divide by zero: E0 enters BYZERO, and `ready_o` is high from E1 (latency 1).
- `ready_o` is high for as long as `start_i` stays high after completion, with a minimum of 1 cycle.
- After `start_i` drops, the next start is accepted on the edge after returning to FREE. Back-to-back throughput is therefore 1 result per WIDTH+3 cycles.
- All outputs are registered; no combinational path runs from inputs to outputs.

## Test plan
- **Unsigned divide.** DIVU 100/7, `start_i` held.
  - `ready_o` rises 33 cycles after E0.
  - `result_o`=0x00000002_0000000E.
  - Drop `start_i`: `ready_o`=0 and `result_o`=0 one edge later.
- **Signed divide.** DIV -7/2 (0xFFFFFFF9 / 0x00000002): `result_o`=0xFFFFFFFF_FFFFFFFD. Also run 7/-2 → 0x00000001_FFFFFFFD.
- **Divide by zero.** DIV 5/0: `ready_o` at E1 and `result_o`=0. Then DIVU 0xFFFFFFFF/1 → 0x00000000_FFFFFFFF at 33 cycles.
- **Annul mid-operation.** Assert `annul_i` at iteration 10.
  - `ready_o` never rises and the state returns to FREE.
  - A following DIVU 9/3 completes normally: 0x00000000_00000003.
- **Reset mid-operation.** Drive `Rst_n`=0 at iteration 20. All outputs are 0 on the next edge; restart DIV 0x80000000/0xFFFFFFFF → 0x00000000_80000000.
- **Result hold.** In END, hold `start_i` 5 extra cycles while changing operands: `result_o` stays stable. Assert `annul_i` in END: FREE and `ready_o`=0 next edge.
